// File: rtl/obstacle_sequencer.sv
// Obstacle launch sequencer: IDLE -> GAP -> LAUNCH -> RUN loop with an LFSR-based pick
// that never repeats the previous obstacle. Define OBSTACLE_TIMEOUT_EN to add a RUN watchdog.
module obstacle_sequencer #(
  parameter int unsigned GAP_CYCLES     = 32000000,
  parameter int unsigned TIMEOUT_CYCLES = 320000000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       play_selected,
  input  logic       menu_on,
  input  logic [3:0] done_in,
  output logic [3:0] selected,
  output logic       done_control,
  output logic       busy,
  output logic [7:0] round_count,
  output logic       timeout
);

  typedef enum logic [1:0] {StIdle, StGap, StLaunch, StRun} state_e;

  localparam logic [25:0] GapLast = 26'(GAP_CYCLES - 1);

  state_e      state_q;
  logic [25:0] gap_cnt_q;
  logic [7:0]  lfsr_q;
  logic [1:0]  last_index_q;

  logic [1:0] candidate;
  logic [1:0] next_index;
  logic [3:0] next_onehot;
  logic       abort;
  logic       hit;
  logic       run_expire;
  logic       finish;

`ifdef OBSTACLE_TIMEOUT_EN
  localparam logic [28:0] TimeoutLast = 29'(TIMEOUT_CYCLES - 1);
  logic [28:0] run_cnt_q;
  assign run_expire = (run_cnt_q == TimeoutLast);
`else
  assign run_expire = 1'b0;
`endif

  always_comb begin
    candidate   = lfsr_q[1:0];
    next_index  = (candidate == last_index_q) ? candidate + 2'd1 : candidate;
    next_onehot = 4'b0001 << next_index;
    abort       = menu_on || !play_selected;
    // Only the bit of the currently selected obstacle can end a RUN.
    hit         = |(done_in & selected);
    finish      = hit || run_expire;
  end

  // Free-running Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1.
  always_ff @(posedge pclk) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= StIdle;
      gap_cnt_q    <= '0;
      last_index_q <= '0;
      selected     <= '0;
      done_control <= 1'b0;
      busy         <= 1'b0;
      round_count  <= '0;
      timeout      <= 1'b0;
`ifdef OBSTACLE_TIMEOUT_EN
      run_cnt_q    <= '0;
`endif
    end else begin
      done_control <= 1'b0;
      timeout      <= 1'b0;
      if (state_q != StIdle && abort) begin
        // Abort beats a same-cycle completion; round_count is left alone.
        state_q   <= StIdle;
        selected  <= '0;
        busy      <= 1'b0;
        gap_cnt_q <= '0;
`ifdef OBSTACLE_TIMEOUT_EN
        run_cnt_q <= '0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            selected <= '0;
            busy     <= 1'b0;
            if (play_selected && !menu_on) begin
              state_q      <= StGap;
              busy         <= 1'b1;
              gap_cnt_q    <= '0;
              round_count  <= '0;
              last_index_q <= '0;
            end
          end
          StGap: begin
            if (gap_cnt_q == GapLast) begin
              state_q      <= StLaunch;
              selected     <= next_onehot;
              done_control <= 1'b1;
              last_index_q <= next_index;
              gap_cnt_q    <= '0;
            end else begin
              gap_cnt_q <= gap_cnt_q + 26'd1;
            end
          end
          StLaunch: begin
            state_q <= StRun;
`ifdef OBSTACLE_TIMEOUT_EN
            run_cnt_q <= '0;
`endif
          end
          StRun: begin
            if (finish) begin
              state_q   <= StGap;
              gap_cnt_q <= '0;
              selected  <= '0;
              timeout   <= run_expire;
              if (round_count != 8'hFF) begin
                round_count <= round_count + 8'd1;
              end
`ifdef OBSTACLE_TIMEOUT_EN
              run_cnt_q <= '0;
            end else begin
              run_cnt_q <= run_cnt_q + 29'd1;
`endif
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/obstacle_sequencer.md
OBSTACLE_SEQUENCER -- requirements
Module: obstacle_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 32000000, pclk cycles between the end of one obstacle and the launch of the next.
REQ-002 Parameter TIMEOUT_CYCLES, default 320000000, maximum RUN duration before forced advance (see REQ-030).
REQ-003 pclk  input  1  pixel clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 play_selected  input  1  game-play mode requested.
REQ-006 menu_on  input  1  menu displayed; aborts play.
REQ-007 done_in  input  4  per-obstacle completion pulses, bit i from obstacle i.
REQ-008 selected  output  4  one-hot code of the active obstacle; 4'b0000 when none.
REQ-009 done_control  output  1  one-cycle launch strobe to all obstacle blocks.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 round_count  output  8  obstacles completed in current game, saturating at 255.
REQ-012 timeout  output  1  one-cycle pulse when an obstacle is force-ended.

Function
REQ-013 The block SHALL implement states IDLE, GAP, LAUNCH, RUN; all outputs registered.
REQ-014 IDLE: selected=0, done_control=0; when play_selected && !menu_on, SHALL go to GAP, clear gap counter, clear round_count and last_index.
REQ-015 GAP: counter SHALL increment each cycle; at GAP_CYCLES-1 SHALL go to LAUNCH and latch next index (REQ-020).
REQ-016 LAUNCH: exactly one cycle; done_control=1 and selected=one-hot of latched index in that same cycle; next state RUN.
REQ-017 RUN: selected SHALL hold stable; done_control=0; when (done_in & selected) != 0, SHALL go to GAP, clear gap counter, increment round_count (saturating).
REQ-018 done_in bits not matching selected SHALL be ignored in every state.
REQ-019 In GAP, LAUNCH or RUN, menu_on || !play_selected SHALL force IDLE next cycle, selected=0, done_control=0; round_count held.
REQ-020 Selection: 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, advancing every cycle; candidate = lfsr[1:0]; if candidate == last_index, index = candidate+1 mod 4; last_index updated at LAUNCH.
REQ-021 Abort and matching done_in in the same cycle: abort SHALL win, round_count not incremented.
REQ-022 round_count SHALL stay 255 once reached; no wrap.
REQ-023 Gap counter 26 bits; RUN counter 29 bits; both cleared on every state entry.
REQ-024 Launch-to-strobe latency: done_control asserted in cycle GAP_CYCLES after entering GAP.

Reset
REQ-025 On rst: state=IDLE, selected=0, done_control=0, busy=0, round_count=0, timeout=0, lfsr=8'hA5, last_index=0, counters=0.
REQ-026 rst asserted mid-RUN SHALL override all inputs and take effect at the next edge.
REQ-027 rst SHALL have priority over done_in, menu_on and play_selected.

Configuration
REQ-028 Macro OBSTACLE_TIMEOUT_EN SHALL compile the RUN watchdog in or out.
REQ-029 Without OBSTACLE_TIMEOUT_EN: RUN waits indefinitely for done_in; timeout tied 0; RUN counter absent.
REQ-030 With OBSTACLE_TIMEOUT_EN: RUN counter reaching TIMEOUT_CYCLES-1 SHALL be treated as done (REQ-017) and pulse timeout for one cycle; real done_in in the same cycle counts once, timeout still pulses.

Verification (GAP_CYCLES=4, TIMEOUT_CYCLES=16)
REQ-031 Reset, then play_selected=1, menu_on=0 -> busy=1 next cycle; done_control=1 with selected=1<<(lfsr-derived index) exactly 4 cycles after GAP entry; selected one-hot.
REQ-032 In RUN with selected=4'b0100, pulse done_in=4'b0001 -> ignored; then pulse 4'b0100 -> round_count 0->1, GAP entered, selected unchanged during ignored pulse.
REQ-033 Run 20 consecutive obstacles -> no two consecutive launches share the same selected code; round_count=20.
REQ-034 Assert menu_on in same cycle as matching done_in -> IDLE next cycle, selected=0, round_count unchanged, busy=0.
REQ-035 With OBSTACLE_TIMEOUT_EN, never assert done_in -> timeout pulses 16 cycles after RUN entry, round_count+1; without macro -> stays in RUN, timeout=0.
REQ-036 Force round_count to 255 via repeated completions -> remains 255 after further done_in.
